pwm_capture: RTL
================

Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator. Samples an asynchronous PWM line and measures period and high time in clk cycles.
- Reports each completed measurement, plus 0%/100% (static line) events, through a valid/ready result interface.
- Used for loopback checking of the generator and for reading external PWM sources.

Parameters:
- WIDTH, 4, bit width of the period/high counters and results. MAX = 2^WIDTH-1 is the longest measurable period.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- pwm_in  input  1  asynchronous PWM line
- meas_period  output  WIDTH  measured period in cycles (rise to rise)
- meas_high  output  WIDTH  measured high time in cycles (rise to fall)
- meas_kind  output  2  00 normal, 01 static low (0%), 10 static high (100%), 11 unused
- meas_valid  output  1  result register holds an unaccepted result
- meas_ready  input  1  consumer accepts the result when valid&ready
- overrun  output  1  sticky: at least one result dropped while a result was held

Behaviour:
- Reset (async, any time, including mid-measurement):
  - All outputs 0; sync flops, prev-sample, counters and discard flag cleared.
  - Discard flag then set; state ARM.
- Synchroniser:
  - 2-flop sync of pwm_in, then one prev register.
  - rise = s & ~prev; fall = ~s & prev.
  - The fixed 2-cycle sync delay cancels out; it does not alter measured lengths.
- Counters: cnt (period) and hcnt (high), both WIDTH bits, saturate-free by construction (timeout at MAX).
- FSM states: ARM, HIGH, LOW, STUCK.
  - ARM: cnt increments each cycle.
    - rise -> cnt=1, hcnt=1, go HIGH.
    - cnt==MAX with no rise -> publish static (kind 01 if s==0, else 10), go STUCK.
  - HIGH: cnt++, hcnt++ each cycle.
    - fall -> go LOW; hcnt frozen.
    - cnt==MAX with no fall -> publish kind 10, go STUCK.
  - LOW: cnt++ each cycle.
    - rise -> publish normal (period=cnt, high=hcnt) unless discard set; clear discard; cnt=1, hcnt=1; go HIGH.
    - cnt==MAX with no rise -> publish kind 01, go STUCK.
  - STUCK: no further publishes; static event is reported once per episode.
    - rise -> cnt=1, hcnt=1, go HIGH.
    - fall -> cnt=1, go ARM.
- Edge and timeout on the same cycle (cnt==MAX): the edge wins. Period MAX is measurable; minimum measurable period is 2 (high 1, low 1).
- Discard: the first rise-to-rise interval after reset is never published, because a line high at reset release produces a false rise.
- Static publishes force meas_period=0 and meas_high=0.
- Result register and handshake:
  - A publish loads the result register at the clock edge; meas_valid rises the cycle after the publishing edge is sampled.
  - meas_valid holds, with data stable, until valid&ready.
  - Publish while valid & ~ready -> new result dropped, old result kept, overrun set.
  - Publish on the same cycle as valid&ready -> new result loaded, valid stays 1, no overrun.
  - overrun clears on a valid&ready cycle unless a drop occurs that same cycle.
- Arithmetic: plain unsigned WIDTH-bit increments. Wrap cannot occur because the timeout fires at MAX.

Decomposition:
- Shared package pwm_pkg holds:
  - meas_kind encodings: KIND_NORMAL, KIND_STATIC_LO, KIND_STATIC_HI.
  - FSM state encoding: ARM, HIGH, LOW, STUCK.
- One sub-module, pwm_edge_sync: 2-flop synchroniser, prev register, rise/fall outputs, async active-high reset.
- FSM, counters and result register stay in pwm_capture.

Test Plan:
1. Drive pwm_in from the team PWM generator (WIDTH=4) with div=10, duty=5; meas_ready=1.
   -> First interval discarded.
   -> Then meas_period=10, meas_high=5, kind=00, one valid pulse every 10 cycles.
2. Switch the generator to div=10, duty=0.
   -> Last normal result, then 15 cycles after the last rise a single kind=01 result (period=0, high=0).
   -> No further results while the line stays low.
   -> Return to duty=5 gives normal results again (no discard).
3. div=12, duty=12.
   -> Single kind=10 result once the line has been high for cnt==15.
   -> Bench-driven high 3 / low 1 gives period=4, high=3, and checks the minimum-period case.
4. div=10, duty=7 with meas_ready=0 for 3 periods.
   -> meas_period=10, meas_high=7 held stable, overrun=1.
   -> Raise ready: the held result is accepted and overrun clears on that cycle.
5. Bench drives high 5 / low 15 (period 20 > MAX).
   -> kind=01 at timeout; the next rise restarts HIGH; no normal result ever published.
   -> Then high 5 / low 10 gives period=15, high=5 (edge beats timeout).
6. Assert rst for 1 cycle mid-HIGH at div=10, duty=5.
   -> All outputs 0 asynchronously, including a held valid result and overrun.
   -> After release, the first interval is discarded, then period=10, high=5 resume.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared encodings for the PWM capture block: result kinds and FSM states.
package pwm_pkg;

    typedef enum logic [1:0] {
        KIND_NORMAL    = 2'b00,
        KIND_STATIC_LO = 2'b01,
        KIND_STATIC_HI = 2'b10
    } kind_e;

    typedef enum logic [1:0] {
        ARM   = 2'b00,
        HIGH  = 2'b01,
        LOW   = 2'b10,
        STUCK = 2'b11
    } state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchroniser for the asynchronous PWM line plus a one-cycle history
// register, producing the synchronised level and single-cycle rise/fall strobes.
module pwm_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_reg;
    logic       prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b00;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], din};
            prev_reg <= sync_reg[1];
        end
    end

    assign level = sync_reg[1];
    assign rise  = sync_reg[1] & ~prev_reg;
    assign fall  = ~sync_reg[1] & prev_reg;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM line in clk cycles and
// reports each measurement, or a static-line event, through a valid/ready register.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] meas_period,
    output logic [WIDTH-1:0] meas_high,
    output logic [1:0]       meas_kind,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             overrun
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic level, rise, fall;

    pwm_edge_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    state_e           state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] hcnt_reg, hcnt_next;
    logic             discard_reg, discard_next;

    logic             pub;
    kind_e            pub_kind;
    logic [WIDTH-1:0] pub_period;
    logic [WIDTH-1:0] pub_high;

    logic [WIDTH-1:0] period_reg, high_reg;
    logic [1:0]       kind_reg;
    logic             valid_reg, overrun_reg;
    logic             accept, drop;

    // Edges are checked before the MAX timeout so that a period of exactly MAX is measurable.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        hcnt_next    = hcnt_reg;
        discard_next = discard_reg;
        pub          = 1'b0;
        pub_kind     = KIND_NORMAL;
        pub_period   = '0;
        pub_high     = '0;
        case (state_reg)
            ARM: begin
                if (rise) begin
                    cnt_next   = ONE;
                    hcnt_next  = ONE;
                    state_next = HIGH;
                end else if (cnt_reg == MAX) begin
                    pub        = 1'b1;
                    pub_kind   = level ? KIND_STATIC_HI : KIND_STATIC_LO;
                    state_next = STUCK;
                end else begin
                    cnt_next = cnt_reg + ONE;
                end
            end
            HIGH: begin
                if (fall) begin
                    // A fall at MAX leaves an unmeasurable period; hold at MAX so LOW times out.
                    cnt_next   = (cnt_reg == MAX) ? MAX : cnt_reg + ONE;
                    state_next = LOW;
                end else if (cnt_reg == MAX) begin
                    pub        = 1'b1;
                    pub_kind   = KIND_STATIC_HI;
                    state_next = STUCK;
                end else begin
                    cnt_next  = cnt_reg + ONE;
                    hcnt_next = hcnt_reg + ONE;
                end
            end
            LOW: begin
                if (rise) begin
                    pub          = ~discard_reg;
                    pub_period   = cnt_reg;
                    pub_high     = hcnt_reg;
                    discard_next = 1'b0;
                    cnt_next     = ONE;
                    hcnt_next    = ONE;
                    state_next   = HIGH;
                end else if (cnt_reg == MAX) begin
                    pub        = 1'b1;
                    pub_kind   = KIND_STATIC_LO;
                    state_next = STUCK;
                end else begin
                    cnt_next = cnt_reg + ONE;
                end
            end
            STUCK: begin
                if (rise) begin
                    cnt_next   = ONE;
                    hcnt_next  = ONE;
                    state_next = HIGH;
                end else if (fall) begin
                    cnt_next   = ONE;
                    state_next = ARM;
                end
            end
            default: state_next = ARM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ARM;
            cnt_reg     <= '0;
            hcnt_reg    <= '0;
            discard_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            hcnt_reg    <= hcnt_next;
            discard_reg <= discard_next;
        end
    end

    assign accept = valid_reg & meas_ready;
    assign drop   = pub & valid_reg & ~meas_ready;

    // A publish coinciding with acceptance replaces the outgoing result without a drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_reg  <= '0;
            high_reg    <= '0;
            kind_reg    <= 2'b00;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (pub && (!valid_reg || meas_ready)) begin
                period_reg <= pub_period;
                high_reg   <= pub_high;
                kind_reg   <= pub_kind;
                valid_reg  <= 1'b1;
            end else if (accept) begin
                valid_reg <= 1'b0;
            end
            if (drop) begin
                overrun_reg <= 1'b1;
            end else if (accept) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign meas_period = period_reg;
    assign meas_high   = high_reg;
    assign meas_kind   = kind_reg;
    assign meas_valid  = valid_reg;
    assign overrun     = overrun_reg;

endmodule
